// File: rtl/matvec_row_scheduler.sv
// Row sequencer for the dot-product engine: per row, issues ceil(row_len/no_of_units) chunk reads,
// waits for the engine result and hands it out tagged with the row index. Optional MATVEC_SCHED_PERF_EN adds perf_stall.
module matvec_row_scheduler #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  parameter int addr_width    = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [addr_width-1:0]    n_rows,
  input  logic [31:0]              row_len,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [addr_width-1:0]    rd_row,
  output logic [addr_width-1:0]    rd_chunk,
  output logic                     dp_load,
  input  logic                     dp_ready,
  input  logic                     dp_finish,
  input  logic [element_width-1:0] dp_result,
  output logic                     res_valid,
  output logic [addr_width-1:0]    res_row,
  output logic [element_width-1:0] res_data,
  input  logic                     res_ready,
  output logic [2:0]               fsm_state
`ifdef MATVEC_SCHED_PERF_EN
  ,
  output logic [31:0]              perf_stall
`endif
);

  localparam int                    shift     = $clog2(no_of_units);
  localparam logic [31:0]           round_up  = 32'(no_of_units - 1);
  localparam logic [addr_width-1:0] one_a     = addr_width'(1);

  typedef enum logic [2:0] {
    s_idle  = 3'd0,
    s_check = 3'd1,
    s_issue = 3'd2,
    s_wait  = 3'd3,
    s_out   = 3'd4,
    s_done  = 3'd5
  } state_t;

  state_t                state;
  logic [addr_width-1:0] row;
  logic [addr_width-1:0] rows_total;
  logic [31:0]           nch;
  logic                  last_chunk;

  // Result port is valid/ready: a result transfers on any cycle where res_valid && res_ready;
  // res_row/res_data hold while res_valid is high and res_ready is low.
  assign last_chunk = ({{(32-addr_width){1'b0}}, rd_chunk} == (nch - 32'd1));
  assign fsm_state  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= s_idle;
      row        <= '0;
      rows_total <= '0;
      nch        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      rd_row     <= '0;
      rd_chunk   <= '0;
      dp_load    <= 1'b0;
      res_valid  <= 1'b0;
      res_row    <= '0;
      res_data   <= '0;
    end else begin
      dp_load <= rd_en;
      done    <= 1'b0;
      case (state)
        s_idle: begin
          if (start) begin
            rows_total <= n_rows;
            nch        <= (row_len + round_up) >> shift;
            row        <= '0;
            busy       <= 1'b1;
            state      <= s_check;
          end
        end
        s_check: begin
          if (row == rows_total) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= s_done;
          end else if (nch == 32'd0) begin
            // Empty rows never touch the engine; their dot product is zero by definition.
            res_valid <= 1'b1;
            res_row   <= row;
            res_data  <= '0;
            state     <= s_out;
          end else if (dp_ready) begin
            rd_en    <= 1'b1;
            rd_row   <= row;
            rd_chunk <= '0;
            state    <= s_issue;
          end
        end
        s_issue: begin
          if (last_chunk) begin
            rd_en <= 1'b0;
            state <= s_wait;
          end else begin
            rd_chunk <= rd_chunk + one_a;
          end
        end
        s_wait: begin
          if (dp_finish) begin
            res_valid <= 1'b1;
            res_row   <= row;
            res_data  <= dp_result;
            state     <= s_out;
          end
        end
        s_out: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            row       <= row + one_a;
            state     <= s_check;
          end
        end
        s_done:  state <= s_idle;
        default: state <= s_idle;
      endcase
    end
  end

`ifdef MATVEC_SCHED_PERF_EN
  logic stall;
  assign stall = ((state == s_check) && (row != rows_total) && (nch != 32'd0) && !dp_ready) ||
                 ((state == s_out) && !res_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall <= '0;
    end else if ((state == s_idle) && start) begin
      perf_stall <= '0;
    end else if (stall && (perf_stall != 32'hFFFF_FFFF)) begin
      perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_matvec_row_scheduler.sv
// Directed bench for matvec_row_scheduler with a small engine model that returns row*10
// one cycle after the last dp_load of a row.
module tb_matvec_row_scheduler;
  localparam int EW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] n_rows = '0;
  logic [31:0]   row_len = '0;
  logic          busy, done, rd_en, dp_load, res_valid;
  logic [AW-1:0] rd_row, rd_chunk, res_row;
  logic          dp_ready = 1'b1;
  logic          dp_finish = 1'b0;
  logic [EW-1:0] dp_result = '0;
  logic [EW-1:0] res_data;
  logic          res_ready = 1'b1;
  logic [2:0]    fsm_state;
`ifdef MATVEC_SCHED_PERF_EN
  logic [31:0]   perf_stall;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [41:0] rd_log[$];
  int          rd_cyc[$];
  logic [41:0] res_log[$];
  logic [41:0] exp_q[$];
  int          hs_cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          busy_in_done = 0;
  int          load_cnt = 0;

  logic          stray_req = 1'b0;
  logic          prev_load = 1'b0;
  logic [AW-1:0] eng_row = '0;

  matvec_row_scheduler #(.element_width(EW), .no_of_units(8), .addr_width(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .n_rows(n_rows), .row_len(row_len),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_row(rd_row), .rd_chunk(rd_chunk),
    .dp_load(dp_load), .dp_ready(dp_ready), .dp_finish(dp_finish), .dp_result(dp_result),
    .res_valid(res_valid), .res_row(res_row), .res_data(res_data), .res_ready(res_ready),
    .fsm_state(fsm_state)
`ifdef MATVEC_SCHED_PERF_EN
    , .perf_stall(perf_stall)
`endif
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: finish pulse on the cycle after the last load; stray_req forces a bogus finish.
  always @(negedge clk) begin
    if (rd_en) eng_row = rd_row;
    if (stray_req) begin
      dp_finish = 1'b1;
      dp_result = 32'hDEAD_BEEF;
    end else if (prev_load && !dp_load) begin
      dp_finish = 1'b1;
      dp_result = 32'(eng_row) * 32'd10;
    end else begin
      dp_finish = 1'b0;
      dp_result = '0;
    end
    prev_load = dp_load;
  end

  // Monitor
  always @(negedge clk) begin
    if (rd_en) begin
      rd_log.push_back({22'd0, rd_row, rd_chunk});
      rd_cyc.push_back(cyc);
    end
    if (res_valid && res_ready) begin
      res_log.push_back({res_row, res_data});
      hs_cyc = cyc;
    end
    if (dp_load) load_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (busy) busy_in_done++;
    end
  end

  // Driver tasks
  task automatic pulse_start(input logic [AW-1:0] n, input logic [31:0] len, output int s_cyc);
    @(posedge clk); #1;
    n_rows = n; row_len = len; start = 1'b1; s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk); #1;
      if (done_cnt > base) ok = 1'b1;
    end
  endtask

  task automatic wait_rd_row(input logic [AW-1:0] r, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (rd_en && rd_row == r) ok = 1'b1;
    end
  endtask

  task automatic push_results(input int n, input bit zero);
    exp_q.delete();
    for (int r = 0; r < n; r++) exp_q.push_back({10'(r), zero ? 32'd0 : 32'(r * 10)});
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, rd_en, dp_load, res_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000", {busy, done, rd_en, dp_load, res_valid});
    end
    checks++;
    if ({rd_row, rd_chunk, res_row} !== 30'd0) begin
      errors++; $display("FAIL reset_idx got %h exp 0", {rd_row, rd_chunk, res_row});
    end
    checks++;
    if (res_data !== 32'd0) begin
      errors++; $display("FAIL reset_data got %h exp 0", res_data);
    end
    checks++;
    if (fsm_state !== 3'd0) begin
      errors++; $display("FAIL reset_state got %0d exp 0", fsm_state);
    end
`ifdef MATVEC_SCHED_PERF_EN
    checks++;
    if (perf_stall !== 32'd0) begin
      errors++; $display("FAIL reset_perf got %0d exp 0", perf_stall);
    end
`endif
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int s; bit ok; int rb, qb, db, lb;
    rb = rd_log.size(); qb = res_log.size(); db = done_cnt; lb = load_cnt;
    pulse_start(10'd3, 32'd16, s);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
    wait_done(db, 300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout got no done exp done"); end
    exp_q.delete();
    for (int r = 0; r < 3; r++) for (int c = 0; c < 2; c++) exp_q.push_back({22'd0, 10'(r), 10'(c)});
    checks++;
    if (rd_log.size() - rb != exp_q.size()) begin
      errors++; $display("FAIL basic_rd_count got %0d exp %0d", rd_log.size() - rb, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rd_log[rb + i] !== exp_q[i]) begin
          errors++; $display("FAIL basic_rd[%0d] got %h exp %h", i, rd_log[rb + i], exp_q[i]);
        end
      end
      checks++;
      if (rd_cyc[rb] !== s + 2) begin
        errors++; $display("FAIL basic_first_rd_cycle got %0d exp %0d", rd_cyc[rb], s + 2);
      end
      checks++;
      if (rd_cyc[rb + 1] !== rd_cyc[rb] + 1) begin
        errors++; $display("FAIL basic_gapfree got %0d exp %0d", rd_cyc[rb + 1], rd_cyc[rb] + 1);
      end
    end
    push_results(3, 1'b0);
    checks++;
    if (res_log.size() - qb != 3) begin
      errors++; $display("FAIL basic_res_count got %0d exp 3", res_log.size() - qb);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (res_log[qb + i] !== exp_q[i]) begin
          errors++; $display("FAIL basic_res[%0d] got %h exp %h", i, res_log[qb + i], exp_q[i]);
        end
      end
    end
    checks++;
    if (load_cnt - lb !== 6) begin errors++; $display("FAIL basic_loads got %0d exp 6", load_cnt - lb); end
    checks++;
    if (done_cyc !== hs_cyc + 2) begin
      errors++; $display("FAIL basic_done_latency got %0d exp %0d", done_cyc, hs_cyc + 2);
    end
    checks++;
    if (busy_in_done !== 0) begin errors++; $display("FAIL basic_busy_in_done got %0d exp 0", busy_in_done); end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00 || done_cnt - db !== 1) begin
      errors++; $display("FAIL basic_done_pulse got done=%b busy=%b cnt=%0d exp 0 0 1", done, busy, done_cnt - db);
    end
  endtask

  task automatic test_chunk_rounding;
    int s; bit ok; int rb, qb, db;
    rb = rd_log.size(); qb = res_log.size(); db = done_cnt;
    pulse_start(10'd2, 32'd17, s);
    wait_done(db, 300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL len17_timeout got no done exp done"); end
    exp_q.delete();
    for (int r = 0; r < 2; r++) for (int c = 0; c < 3; c++) exp_q.push_back({22'd0, 10'(r), 10'(c)});
    checks++;
    if (rd_log.size() - rb != exp_q.size()) begin
      errors++; $display("FAIL len17_rd_count got %0d exp %0d", rd_log.size() - rb, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rd_log[rb + i] !== exp_q[i]) begin
          errors++; $display("FAIL len17_rd[%0d] got %h exp %h", i, rd_log[rb + i], exp_q[i]);
        end
      end
    end
    push_results(2, 1'b0);
    checks++;
    if (res_log.size() - qb != 2 || res_log[qb + 1] !== exp_q[1]) begin
      errors++; $display("FAIL len17_res got n=%0d last=%h exp n=2 last=%h", res_log.size() - qb, res_log[res_log.size() - 1], exp_q[1]);
    end
    // Zero-length rows: no reads, zero results
    rb = rd_log.size(); qb = res_log.size(); db = done_cnt;
    pulse_start(10'd2, 32'd0, s);
    wait_done(db, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL len0_timeout got no done exp done"); end
    checks++;
    if (rd_log.size() - rb != 0) begin errors++; $display("FAIL len0_rd_count got %0d exp 0", rd_log.size() - rb); end
    push_results(2, 1'b1);
    checks++;
    if (res_log.size() - qb != 2) begin
      errors++; $display("FAIL len0_res_count got %0d exp 2", res_log.size() - qb);
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (res_log[qb + i] !== exp_q[i]) begin
          errors++; $display("FAIL len0_res[%0d] got %h exp %h", i, res_log[qb + i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int s, hs; bit ok; int rb, qb, db;
    rb = rd_log.size(); qb = res_log.size(); db = done_cnt;
    pulse_start(10'd3, 32'd8, s);
    wait_rd_row(10'd1, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_row1_issue got none exp rd_en row 1"); end
    @(posedge clk); #1;
    res_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (res_valid) ok = 1'b1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_valid_timeout got none exp res_valid"); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_row !== 10'd1 || res_data !== 32'd10 || rd_en !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b row=%0d data=%0d rd=%b exp 1 1 10 0", i, res_valid, res_row, res_data, rd_en);
      end
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    hs = cyc;
    wait_done(db, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout got no done exp done"); end
    checks++;
    if (rd_log.size() - rb != 3) begin
      errors++; $display("FAIL bp_rd_count got %0d exp 3", rd_log.size() - rb);
    end else begin
      checks++;
      if (rd_log[rb + 2] !== {22'd0, 10'd2, 10'd0} || rd_cyc[rb + 2] !== hs + 2) begin
        errors++; $display("FAIL bp_row2_issue got %h@%0d exp row2@%0d", rd_log[rb + 2], rd_cyc[rb + 2], hs + 2);
      end
    end
    push_results(3, 1'b0);
    checks++;
    if (res_log.size() - qb != 3 || res_log[qb + 1] !== exp_q[1] || res_log[qb + 2] !== exp_q[2]) begin
      errors++; $display("FAIL bp_results got n=%0d exp 3 with (1,10),(2,20)", res_log.size() - qb);
    end
`ifdef MATVEC_SCHED_PERF_EN
    checks++;
    if (perf_stall !== 32'd5) begin errors++; $display("FAIL bp_perf got %0d exp 5", perf_stall); end
`endif
  endtask

  task automatic test_dp_ready_stall;
    int s; bit ok; int rb, qb, db;
    rb = rd_log.size(); qb = res_log.size(); db = done_cnt;
    dp_ready = 1'b0;
    pulse_start(10'd1, 32'd24, s);
    repeat (4) @(posedge clk);
    #1 dp_ready = 1'b1;
    wait_rd_row(10'd0, 50, ok);
    checks++;
    if (!ok || cyc !== s + 6) begin
      errors++; $display("FAIL stall_first_rd got ok=%b cyc=%0d exp cyc %0d", ok, cyc, s + 6);
    end
    #1 stray_req = 1'b1;
    @(negedge clk); #1;
    stray_req = 1'b0;
    wait_done(db, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_timeout got no done exp done"); end
    checks++;
    if (rd_log.size() - rb != 3) begin errors++; $display("FAIL stall_rd_count got %0d exp 3", rd_log.size() - rb); end
    checks++;
    if (res_log.size() - qb != 1 || res_log[res_log.size() - 1] !== 42'd0) begin
      errors++; $display("FAIL stray_finish got n=%0d last=%h exp n=1 (0,0)", res_log.size() - qb, res_log[res_log.size() - 1]);
    end
`ifdef MATVEC_SCHED_PERF_EN
    checks++;
    if (perf_stall !== 32'd4) begin errors++; $display("FAIL stall_perf got %0d exp 4", perf_stall); end
`endif
  endtask

  task automatic test_reset_mid;
    int s; bit ok; int rb, qb, db;
    pulse_start(10'd3, 32'd16, s);
    wait_rd_row(10'd1, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rmid_row1 got none exp rd_en row 1"); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, rd_en, dp_load, res_valid} !== 5'b0 || {rd_row, rd_chunk, res_row} !== 30'd0 ||
        res_data !== 32'd0 || fsm_state !== 3'd0) begin
      errors++; $display("FAIL rmid_outputs got ctrl=%b idx=%h data=%h st=%0d exp all 0",
                         {busy, done, rd_en, dp_load, res_valid}, {rd_row, rd_chunk, res_row}, res_data, fsm_state);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    rb = rd_log.size(); qb = res_log.size(); db = done_cnt;
    pulse_start(10'd1, 32'd8, s);
    wait_done(db, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rmid_restart_timeout got no done exp done"); end
    checks++;
    if (rd_log.size() - rb != 1 || rd_log[rd_log.size() - 1] !== 42'd0) begin
      errors++; $display("FAIL rmid_restart_rd got n=%0d last=%h exp 1 (0,0)", rd_log.size() - rb, rd_log[rd_log.size() - 1]);
    end
    checks++;
    if (res_log.size() - qb != 1 || res_log[res_log.size() - 1] !== 42'd0) begin
      errors++; $display("FAIL rmid_restart_res got n=%0d last=%h exp 1 (0,0)", res_log.size() - qb, res_log[res_log.size() - 1]);
    end
  endtask

  task automatic test_back_to_back;
    int s; bit ok; int rb, qb, db;
    rb = rd_log.size(); qb = res_log.size(); db = done_cnt;
    pulse_start(10'd0, 32'd8, s);
    wait_done(db, 20, ok);
    checks++;
    if (!ok || done_cyc !== s + 2) begin
      errors++; $display("FAIL nrows0_done got ok=%b cyc=%0d exp cyc %0d", ok, done_cyc, s + 2);
    end
    checks++;
    if (rd_log.size() - rb != 0 || res_log.size() - qb != 0) begin
      errors++; $display("FAIL nrows0_activity got rd=%0d res=%0d exp 0 0", rd_log.size() - rb, res_log.size() - qb);
    end
    // Start while busy must be ignored
    qb = res_log.size(); db = done_cnt;
    pulse_start(10'd2, 32'd8, s);
    @(posedge clk); #1;
    n_rows = 10'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(db, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL busy_start_timeout got no done exp done"); end
    repeat (10) @(negedge clk);
    push_results(2, 1'b0);
    checks++;
    if (res_log.size() - qb != 2 || res_log[qb + 1] !== exp_q[1] || done_cnt - db != 1) begin
      errors++; $display("FAIL busy_start_ignored got res=%0d done=%0d exp 2 1", res_log.size() - qb, done_cnt - db);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_chunk_rounding;
    test_backpressure;
    test_dp_ready_stall;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
